falu_sgnj_issue_sched: RTL and testbench
========================================

// Module: falu_sgnj_issue_sched
// PURPOSE
//  Shares one combinational FSGNJ sign-injection datapath between two FP issue slots.
//  Round-robin arbitrates requests and drives the FSGNJ operand/control inputs from the winner.
//  Registers the FSGNJ result into a one-entry output stage and hands it to FP writeback with valid/ready.
//  Sits between the FP reservation-station issue ports and the FP writeback/CDB arbiter.
// PARAMETERS
//  TAG_W    6   width of destination/ROB tag carried with each op
// PORTS
//  CLK           in   1      core clock; all state updates on rising edge
//  RST_N         in   1      asynchronous active-low reset
//  FLUSH         in   1      pipeline flush; kills held result and blocks grants this cycle
//  REQn_VALID    in   1      (n=0,1) slot n presents an op
//  REQn_READY    out  1      (n=0,1) slot n op accepted this cycle (VALID&READY = fire)
//  REQn_OPA      in   64     (n=0,1) rs1 operand (NaN-boxed when single)
//  REQn_OPB      in   64     (n=0,1) rs2 operand
//  REQn_FN       in   2      (n=0,1) 00 FSGNJ, 01 FSGNJN, 10 FSGNJX, 11 reserved
//  REQn_DBL      in   1      (n=0,1) 1 = double, 0 = single
//  REQn_TAG      in   TAG_W  (n=0,1) destination tag
//  SG_IN1        out  64     to FSGNJ INPUT_1
//  SG_IN2        out  64     to FSGNJ INPUT_2
//  SG_DBL        out  1      to FSGNJ IsDouble
//  SG_SI         out  1      to FSGNJ Is_SI
//  SG_SI_NEG     out  1      to FSGNJ Is_SI_NEG
//  SG_SI_XOR     out  1      to FSGNJ Is_SI_XOR
//  SG_RESULT     in   64     from FSGNJ OUTPUT (combinational)
//  WB_VALID      out  1      result held in output stage
//  WB_READY      in   1      writeback accepts result
//  WB_DATA       out  64     registered result
//  WB_TAG        out  TAG_W  tag of registered result
//  WB_SRC        out  1      slot (0/1) that issued the held result
// BEHAVIOUR
//  Reset (RST_N=0, async): WB_VALID=0, WB_DATA=0, WB_TAG=0, WB_SRC=0, FSM=EMPTY, LAST=1.
//  FSM: EMPTY (WB_VALID=0), FULL (WB_VALID=1).
//  CAN_ACCEPT = ~FLUSH & (EMPTY | WB_READY). REQn_READY=0 whenever CAN_ACCEPT=0.
//  Arbitration: both valid -> grant slot != LAST; one valid -> that slot. LAST updates only on fire.
//  REQn_READY = CAN_ACCEPT & grant_n; at most one READY high per cycle; READY never depends on itself.
//  SG_* driven combinationally from granted slot; FN decode one-hot: 00->SI, 01->SI_NEG, 10->SI_XOR.
//  FN=11: all three SG_SI* = 0 (sign forced 0); op still accepted and written back.
//  No grant: SG_IN1/SG_IN2=0, SG_DBL=0, SG_SI*=0.
//  Fire: WB_DATA<=SG_RESULT, WB_TAG<=REQn_TAG, WB_SRC<=n, FSM->FULL. Latency 1 cycle, fire to WB_VALID.
//  FULL & WB_READY & no fire -> EMPTY. FULL & WB_READY & fire -> stays FULL, new data (back-to-back, 1 op/cycle).
//  FULL & ~WB_READY: WB_DATA/TAG/SRC held stable, no grants.
//  FLUSH=1: next FSM=EMPTY (held result dropped even if WB_READY=1), no fire, LAST unchanged.
//  Reset asserted mid-operation: held result discarded immediately, outputs to reset values.
//  WB_DATA/TAG/SRC change only on fire or reset; no X propagation when idle.
// TESTING
//  Single: REQ0 FN=00 DBL=1 OPA=3FF0000000000000 OPB=8000000000000000 -> next cycle WB_VALID=1 WB_DATA=BFF0000000000000.
//  Single-prec NaN-box: REQ1 FN=01 DBL=0 OPA=FFFFFFFF3F800000 OPB=FFFFFFFF3F800000 -> WB_DATA=FFFFFFFFBF800000, WB_SRC=1.
//  Fairness: both slots valid 4 cycles, WB_READY=1 -> grants 0,1,0,1; 4 results in consecutive cycles.
//  Backpressure: WB_READY=0 for 3 cycles while FULL -> both READY=0, WB_DATA stable; WB_READY=1 -> next op fires same cycle.
//  Flush: FULL with WB_READY=1 and FLUSH=1 -> no fire, next cycle WB_VALID=0; LAST unchanged.
//  Reset mid-op: RST_N low asynchronously while FULL -> WB_VALID=0 without clock edge; after release REQ0 granted first.

Source files
------------

// File: rtl/falu_sgnj_issue_sched.sv
// falu_sgnj_issue_sched
// Shares one combinational FSGNJ sign-injection unit between two FP issue
// slots. A round-robin arbiter picks a slot and steers its operands and
// decoded function onto the SG_* bus. The unit's result is captured in a
// one-entry output stage that is offered to FP writeback.
//
// Handshake (applies to req0/req1 and to writeback): a transfer happens on a
// rising clock edge where valid and ready are both high. A producer holds
// valid and its payload steady until that edge. req*_ready is computed from
// flush, wb_ready and the output-stage state only, so it never depends on
// the requester's own ready. wb_valid stays high and wb_data/wb_tag/wb_src
// stay stable until a cycle where wb_ready is high.

module falu_sgnj_issue_sched #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [63:0]      req0_opa,
    input  logic [63:0]      req0_opb,
    input  logic [1:0]       req0_fn,
    input  logic             req0_dbl,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [63:0]      req1_opa,
    input  logic [63:0]      req1_opb,
    input  logic [1:0]       req1_fn,
    input  logic             req1_dbl,
    input  logic [TAG_W-1:0] req1_tag,

    output logic [63:0]      sg_in1,
    output logic [63:0]      sg_in2,
    output logic             sg_dbl,
    output logic             sg_si,
    output logic             sg_si_neg,
    output logic             sg_si_xor,
    input  logic [63:0]      sg_result,

    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [63:0]      wb_data,
    output logic [TAG_W-1:0] wb_tag,
    output logic             wb_src,

    output logic             dbg_state
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic             last;        // slot that fired most recently
    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic             fire;
    logic [1:0]       sel_fn;
    logic [TAG_W-1:0] sel_tag;

    assign wb_valid  = (state == FULL);
    assign dbg_state = state;

    // The output stage can take a new result when it is empty or is being drained this cycle.
    assign can_accept = ~flush & ((state == EMPTY) | wb_ready);

    // Round-robin grant: on contention the slot that did not fire last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (can_accept) begin
            if (req0_valid && req1_valid) begin
                grant0 = last;
                grant1 = ~last;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign fire       = grant0 | grant1;

    // Steer the granted slot onto the sign-injection bus; everything is zero with no grant.
    always_comb begin
        sg_in1    = 64'd0;
        sg_in2    = 64'd0;
        sg_dbl    = 1'b0;
        sel_fn    = 2'b11;
        sel_tag   = '0;
        if (grant0) begin
            sg_in1  = req0_opa;
            sg_in2  = req0_opb;
            sg_dbl  = req0_dbl;
            sel_fn  = req0_fn;
            sel_tag = req0_tag;
        end else if (grant1) begin
            sg_in1  = req1_opa;
            sg_in2  = req1_opb;
            sg_dbl  = req1_dbl;
            sel_fn  = req1_fn;
            sel_tag = req1_tag;
        end
    end

    // One-hot function decode; the reserved code leaves all three low so the sign is forced to 0.
    always_comb begin
        sg_si     = 1'b0;
        sg_si_neg = 1'b0;
        sg_si_xor = 1'b0;
        if (fire) begin
            case (sel_fn)
                2'b00:   sg_si     = 1'b1;
                2'b01:   sg_si_neg = 1'b1;
                2'b10:   sg_si_xor = 1'b1;
                default: ;
            endcase
        end
    end

    // Output-stage FSM with its payload registers and the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            last    <= 1'b1;
            wb_data <= 64'd0;
            wb_tag  <= '0;
            wb_src  <= 1'b0;
        end else begin
            if (fire) begin
                wb_data <= sg_result;
                wb_tag  <= sel_tag;
                wb_src  <= grant1;
                last    <= grant1;
            end
            case (state)
                EMPTY: begin
                    if (fire) state <= FULL;
                end
                FULL: begin
                    // A flush drops the held result even if writeback would have taken it.
                    if (flush)                 state <= EMPTY;
                    else if (wb_ready && !fire) state <= EMPTY;
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_falu_sgnj_issue_sched.sv
// Bench for falu_sgnj_issue_sched: directed steps, an FSGNJ reference
// unit driving sg_result, and a scoreboard of expected writeback results.

module tb_falu_sgnj_issue_sched;

    localparam int TAG_W = 6;
    localparam int EXP_W = 64 + TAG_W + 1;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [63:0]      req0_opa, req0_opb, req1_opa, req1_opb;
    logic [1:0]       req0_fn, req1_fn;
    logic             req0_dbl, req1_dbl;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic [63:0]      sg_in1, sg_in2, sg_result;
    logic             sg_dbl, sg_si, sg_si_neg, sg_si_xor;
    logic             wb_valid, wb_ready, wb_src, dbg_state;
    logic [63:0]      wb_data;
    logic [TAG_W-1:0] wb_tag;

    // Per-slot request fields written by the driver task.
    logic             r_valid [2];
    logic [63:0]      r_opa   [2];
    logic [63:0]      r_opb   [2];
    logic [1:0]       r_fn    [2];
    logic             r_dbl   [2];
    logic [TAG_W-1:0] r_tag   [2];

    logic [EXP_W-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    logic [63:0] held;

    assign req0_valid = r_valid[0];
    assign req0_opa   = r_opa[0];
    assign req0_opb   = r_opb[0];
    assign req0_fn    = r_fn[0];
    assign req0_dbl   = r_dbl[0];
    assign req0_tag   = r_tag[0];
    assign req1_valid = r_valid[1];
    assign req1_opa   = r_opa[1];
    assign req1_opb   = r_opb[1];
    assign req1_fn    = r_fn[1];
    assign req1_dbl   = r_dbl[1];
    assign req1_tag   = r_tag[1];

    falu_sgnj_issue_sched #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opa(req0_opa),
        .req0_opb(req0_opb), .req0_fn(req0_fn), .req0_dbl(req0_dbl), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opa(req1_opa),
        .req1_opb(req1_opb), .req1_fn(req1_fn), .req1_dbl(req1_dbl), .req1_tag(req1_tag),
        .sg_in1(sg_in1), .sg_in2(sg_in2), .sg_dbl(sg_dbl), .sg_si(sg_si),
        .sg_si_neg(sg_si_neg), .sg_si_xor(sg_si_xor), .sg_result(sg_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_tag(wb_tag), .wb_src(wb_src), .dbg_state(dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External FSGNJ unit: replaces the sign bit of INPUT_1 per the control flags.
    always_comb begin
        logic sa, sb, sgn;
        sa = sg_dbl ? sg_in1[63] : sg_in1[31];
        sb = sg_dbl ? sg_in2[63] : sg_in2[31];
        sgn = 1'b0;
        if (sg_si)          sgn = sb;
        else if (sg_si_neg) sgn = ~sb;
        else if (sg_si_xor) sgn = sa ^ sb;
        sg_result = sg_in1;
        if (sg_dbl) sg_result[63] = sgn;
        else        sg_result[31] = sgn;
    end

    function automatic logic [63:0] sgnj(input logic [63:0] a, input logic [63:0] b,
                                         input logic [1:0] fn, input logic dbl);
        logic [63:0] r;
        int pos;
        logic s;
        pos = dbl ? 63 : 31;
        case (fn)
            2'b00:   s = b[pos];
            2'b01:   s = ~b[pos];
            2'b10:   s = a[pos] ^ b[pos];
            default: s = 1'b0;
        endcase
        r = a;
        r[pos] = s;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", name, obs, exp);
            $error("check %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic set_req(input int slot, input logic [63:0] a, input logic [63:0] b,
                           input logic [1:0] fn, input logic dbl, input logic [TAG_W-1:0] tag);
        r_valid[slot] = 1'b1;
        r_opa[slot]   = a;
        r_opb[slot]   = b;
        r_fn[slot]    = fn;
        r_dbl[slot]   = dbl;
        r_tag[slot]   = tag;
    endtask

    task automatic set_rand(input int slot, input logic [1:0] fn);
        set_req(slot, {$urandom, $urandom}, {$urandom, $urandom}, fn,
                1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 63)));
    endtask

    task automatic clear_req(input int slot);
        r_valid[slot] = 1'b0;
        r_opa[slot]   = 64'd0;
        r_opb[slot]   = 64'd0;
        r_fn[slot]    = 2'b00;
        r_dbl[slot]   = 1'b0;
        r_tag[slot]   = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called at a negedge: the named slot must be granted; push its expected result.
    task automatic expect_issue(input int slot);
        logic [2:0] flags;
        case (r_fn[slot])
            2'b00:   flags = 3'b100;
            2'b01:   flags = 3'b010;
            2'b10:   flags = 3'b001;
            default: flags = 3'b000;
        endcase
        check("ready0", 64'(req0_ready), 64'(slot == 0));
        check("ready1", 64'(req1_ready), 64'(slot == 1));
        check("sg_in1", sg_in1, r_opa[slot]);
        check("sg_in2", sg_in2, r_opb[slot]);
        check("sg_dbl", 64'(sg_dbl), 64'(r_dbl[slot]));
        check("sg_flags", 64'({sg_si, sg_si_neg, sg_si_xor}), 64'(flags));
        exp_q.push_back({sgnj(r_opa[slot], r_opb[slot], r_fn[slot], r_dbl[slot]),
                         r_tag[slot], 1'(slot)});
    endtask

    // Scoreboard: compare each result as writeback takes it.
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (rst_n && wb_valid && wb_ready && !flush) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", 64'(wb_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("wb_data", wb_data, e[EXP_W-1 -: 64]);
                check("wb_tag", 64'(wb_tag), 64'(e[TAG_W:1]));
                check("wb_src", 64'(wb_src), 64'(e[0]));
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        wb_ready = 1'b1;
        clear_req(0);
        clear_req(1);
        held = 64'd0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wb_data", wb_data, 64'd0);
        check("rst_wb_tag", 64'(wb_tag), 64'd0);
        check("rst_wb_src", 64'(wb_src), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        rst_n = 1'b1;

        // Single double-precision FSGNJ from slot 0
        next_cycle();
        set_req(0, 64'h3FF0000000000000, 64'h8000000000000000, 2'b00, 1'b1, 6'd5);
        @(negedge clk);
        expect_issue(0);
        next_cycle();
        clear_req(0);
        @(negedge clk);
        check("single_wb_valid", 64'(wb_valid), 64'd1);
        check("single_wb_data", wb_data, 64'hBFF0000000000000);
        check("idle_sg_in1", sg_in1, 64'd0);
        check("idle_sg_flags", 64'({sg_dbl, sg_si, sg_si_neg, sg_si_xor}), 64'd0);

        // NaN-boxed single FSGNJN from slot 1
        next_cycle();
        set_req(1, 64'hFFFFFFFF3F800000, 64'hFFFFFFFF3F800000, 2'b01, 1'b0, 6'd9);
        @(negedge clk);
        expect_issue(1);
        next_cycle();
        clear_req(1);
        @(negedge clk);
        check("nanbox_wb_data", wb_data, 64'hFFFFFFFFBF800000);
        check("nanbox_wb_src", 64'(wb_src), 64'd1);

        // Fairness: both slots busy for 4 cycles, grants alternate 0,1,0,1
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            set_rand(0, 2'(i));
            set_rand(1, 2'(3 - i));
            @(negedge clk);
            expect_issue(i % 2);
            if (i > 0) check("fair_back_to_back", 64'(wb_valid), 64'd1);
            next_cycle();
        end
        clear_req(0);
        clear_req(1);
        @(negedge clk);

        // Backpressure: hold the result for 3 cycles, then fire as it drains
        next_cycle();
        set_rand(0, 2'b10);
        @(negedge clk);
        held = sgnj(r_opa[0], r_opb[0], r_fn[0], r_dbl[0]);
        expect_issue(0);
        next_cycle();
        wb_ready = 1'b0;
        set_rand(0, 2'b00);
        set_rand(1, 2'b01);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready0", 64'(req0_ready), 64'd0);
            check("bp_ready1", 64'(req1_ready), 64'd0);
            check("bp_wb_valid", 64'(wb_valid), 64'd1);
            check("bp_wb_data_stable", wb_data, held);
            next_cycle();
        end
        wb_ready = 1'b1;
        @(negedge clk);
        expect_issue(1);
        next_cycle();
        clear_req(0);
        clear_req(1);
        @(negedge clk);

        // Flush drops the held result and blocks grants; pointer unchanged
        next_cycle();
        set_rand(0, 2'b00);
        @(negedge clk);
        expect_issue(0);
        next_cycle();
        flush = 1'b1;
        set_rand(0, 2'b01);
        set_rand(1, 2'b10);
        @(negedge clk);
        check("flush_ready0", 64'(req0_ready), 64'd0);
        check("flush_ready1", 64'(req1_ready), 64'd0);
        void'(exp_q.pop_front());
        next_cycle();
        flush = 1'b0;
        clear_req(0);
        clear_req(1);
        @(negedge clk);
        check("flush_wb_valid", 64'(wb_valid), 64'd0);
        next_cycle();
        set_rand(0, 2'b00);
        set_rand(1, 2'b11);
        @(negedge clk);
        expect_issue(1);
        next_cycle();
        clear_req(0);
        clear_req(1);
        @(negedge clk);

        // Asynchronous reset while FULL; slot 0 fired last beforehand
        next_cycle();
        set_rand(0, 2'b10);
        r_tag[0] = 6'd42;
        @(negedge clk);
        expect_issue(0);
        next_cycle();
        clear_req(0);
        wb_ready = 1'b0;
        check("pre_reset_wb_valid", 64'(wb_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_wb_valid", 64'(wb_valid), 64'd0);
        check("async_rst_wb_data", wb_data, 64'd0);
        check("async_rst_wb_tag", 64'(wb_tag), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        wb_ready = 1'b1;
        next_cycle();
        set_rand(0, 2'b01);
        set_rand(1, 2'b00);
        @(negedge clk);
        expect_issue(0);
        next_cycle();
        clear_req(0);
        clear_req(1);
        @(negedge clk);

        // Everything pushed must have been written back
        next_cycle();
        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("final_wb_valid", 64'(wb_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
